// File: rtl/mem_pkt_gate_pkg.sv
// mem_pkt_gate_pkg: FSM state types and header length extraction shared by the packet gate
package mem_pkt_gate_pkg;
  localparam int LEN_W = 8;
  typedef enum logic {IN_HDR, IN_BODY} in_state_e;
  typedef enum logic {OUT_HDR, OUT_BODY} out_state_e;
  function automatic logic [LEN_W-1:0] len_of(input logic [255:0] flit, input int msb, input int lsb);
    logic [255:0] m;
    m = (256'(1) << (msb - lsb + 1)) - 256'(1);
    return LEN_W'((flit >> lsb) & m);
  endfunction
endpackage

// File: rtl/mem_pkt_gate_fifo.sv
// mem_pkt_gate_fifo: flop-based circular buffer with wrap-bit pointers, full/empty/count
module mem_pkt_gate_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + ONE : rd_ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = wr_ptr_q == rd_ptr_q;
  assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule

// File: rtl/mem_pkt_gate.sv
// mem_pkt_gate: store-and-forward packet gate in front of the MC, egress held until init_done; MEM_PKT_GATE_STATS_EN adds packet counters
module mem_pkt_gate
  import mem_pkt_gate_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH = 16,
  parameter int LEN_MSB = 29,
  parameter int LEN_LSB = 22
) (
  input  logic              chipset_clk,
  input  logic              chipset_rst,
  input  logic              init_done,
  input  logic [DATA_W-1:0] flit_in_data,
  input  logic              flit_in_val,
  output logic              flit_in_rdy,
  output logic [DATA_W-1:0] flit_out_data,
  output logic              flit_out_val,
  input  logic              flit_out_rdy,
  output logic              err_oversize,
  output logic [31:0]       stat_pkts_in,
  output logic [31:0]       stat_pkts_out
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);
  in_state_e in_state_q, in_state_d;
  out_state_e out_state_q, out_state_d;
  logic [LEN_W-1:0] rem_in_q, rem_in_d, rem_out_q, rem_out_d, in_len, out_len;
  logic [AW:0] pkt_ready_q, pkt_ready_d, count;
  logic over_q, over_d, err_q, err_d, rdy_q, rdy_d, hold_q, hold_d;
  logic push, pop, commit, start, in_last, out_last, oversize, full, empty;
  mem_pkt_gate_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(chipset_clk),
    .rst(chipset_rst),
    .wr_en(push),
    .wr_data(flit_in_data),
    .rd_en(pop),
    .rd_data(flit_out_data),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign push = flit_in_val && rdy_q;
  assign pop = flit_out_val && flit_out_rdy;
  assign in_len = len_of(256'(flit_in_data), LEN_MSB, LEN_LSB);
  assign out_len = len_of(256'(flit_out_data), LEN_MSB, LEN_LSB);
  assign oversize = 32'(in_len) >= DEPTH;
  assign in_last = push && (in_state_q == IN_HDR ? in_len == '0 : rem_in_q == ONE_L);
  assign out_last = pop && (out_state_q == OUT_HDR ? out_len == '0 : rem_out_q == ONE_L);
  assign start = pop && out_state_q == OUT_HDR;
  always_ff @(posedge chipset_clk) begin
    if (chipset_rst) begin
      in_state_q <= IN_HDR;
      out_state_q <= OUT_HDR;
      rem_in_q <= '0;
      rem_out_q <= '0;
      pkt_ready_q <= '0;
      over_q <= 1'b0;
      err_q <= 1'b0;
      rdy_q <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      in_state_q <= in_state_d;
      out_state_q <= out_state_d;
      rem_in_q <= rem_in_d;
      rem_out_q <= rem_out_d;
      pkt_ready_q <= pkt_ready_d;
      over_q <= over_d;
      err_q <= err_d;
      rdy_q <= rdy_d;
      hold_q <= hold_d;
    end
  end
  always_comb begin
    in_state_d = push ? (in_last ? IN_HDR : IN_BODY) : in_state_q;
    out_state_d = pop ? (out_last ? OUT_HDR : OUT_BODY) : out_state_q;
  end
  always_comb begin
    rem_in_d = !push ? rem_in_q : in_state_q == IN_HDR ? in_len : rem_in_q - ONE_L;
    over_d = push && in_state_q == IN_HDR ? oversize : over_q;
    commit = push && (in_state_q == IN_HDR ? (in_len == '0 || oversize) : (rem_in_q == ONE_L && !over_q));
    err_d = err_q || (push && in_state_q == IN_HDR && oversize);
    rem_out_d = !pop ? rem_out_q : out_state_q == OUT_HDR ? out_len : rem_out_q - ONE_L;
    pkt_ready_d = pkt_ready_q + (commit ? ONE : '0) - (start ? ONE : '0);
    rdy_d = pop ? 1'b1 : push ? count != LAST : !full;
    hold_d = flit_out_val && !flit_out_rdy;
  end
  always_comb begin
    flit_out_val = !empty && (out_state_q == OUT_BODY || (pkt_ready_q != '0 && (init_done || hold_q)));
    flit_in_rdy = rdy_q;
    err_oversize = err_q;
  end
`ifdef MEM_PKT_GATE_STATS_EN
  logic [31:0] st_in_q, st_in_d, st_out_q, st_out_d;
  always_comb begin
    st_in_d = st_in_q + 32'(commit);
    st_out_d = st_out_q + 32'(out_last);
  end
  always_ff @(posedge chipset_clk) begin
    if (chipset_rst) begin
      st_in_q <= '0;
      st_out_q <= '0;
    end else begin
      st_in_q <= st_in_d;
      st_out_q <= st_out_d;
    end
  end
  assign stat_pkts_in = st_in_q;
  assign stat_pkts_out = st_out_q;
`else
  assign stat_pkts_in = 32'd0;
  assign stat_pkts_out = 32'd0;
`endif
endmodule

// File: tb/tb_mem_pkt_gate.sv
// tb_mem_pkt_gate: directed and random packet traffic checked against a packet-level scoreboard
module tb_mem_pkt_gate;
  localparam int DW = 64;
  localparam int DEPTH = 16;
  logic chipset_clk = 1'b0, chipset_rst = 1'b1, init_done = 1'b0;
  logic flit_in_val = 1'b0, flit_out_rdy = 1'b0;
  logic [DW-1:0] flit_in_data = '0;
  logic flit_in_rdy, flit_out_val, err_oversize;
  logic [DW-1:0] flit_out_data;
  logic [31:0] stat_pkts_in, stat_pkts_out;
  mem_pkt_gate dut (
    .chipset_clk(chipset_clk),
    .chipset_rst(chipset_rst),
    .init_done(init_done),
    .flit_in_data(flit_in_data),
    .flit_in_val(flit_in_val),
    .flit_in_rdy(flit_in_rdy),
    .flit_out_data(flit_out_data),
    .flit_out_val(flit_out_val),
    .flit_out_rdy(flit_out_rdy),
    .err_oversize(err_oversize),
    .stat_pkts_in(stat_pkts_in),
    .stat_pkts_out(stat_pkts_out)
  );
  always #5 chipset_clk = ~chipset_clk;
  int vec = 0, errs = 0;
  logic [63:0] sb[$];
  logic [63:0] prev_data = '0;
  int in_left = 0, out_left = 0, released = 0, started = 0, rel_tot = 0, out_tot = 0, since_rst = 0;
  bit in_over = 0, err_m = 0, prev_hold = 0, rst_seen = 0, last_in_fire = 0, last_out_fire = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] mk_hdr(input int len);
    logic [63:0] h;
    h = {$urandom, $urandom};
    h[29:22] = 8'(len);
    return h;
  endfunction
  function automatic int lenf(input logic [63:0] f);
    return int'(f[29:22]);
  endfunction
  // One clock: check and update the model at the falling edge, return just after the rising edge.
  task automatic tick();
    bit exp_val;
    int l;
    logic [63:0] d;
    @(negedge chipset_clk);
    last_in_fire = 0;
    last_out_fire = 0;
    if (rst_seen) begin
      chk("rst_out_val", 64'(flit_out_val), 64'(0));
      chk("rst_in_rdy", 64'(flit_in_rdy), 64'(0));
      chk("rst_err", 64'(err_oversize), 64'(0));
      chk("rst_stats", {stat_pkts_in, stat_pkts_out}, 64'(0));
    end
    rst_seen = chipset_rst;
    if (chipset_rst) begin
      sb.delete();
      in_left = 0; out_left = 0; released = 0; started = 0; rel_tot = 0; out_tot = 0;
      in_over = 0; err_m = 0; prev_hold = 0; since_rst = 0;
      @(posedge chipset_clk); #1;
      return;
    end
    exp_val = sb.size() > 0 && (out_left > 0 || (released > started && (init_done || prev_hold)));
    chk("out_val", 64'(flit_out_val), 64'(exp_val));
    if (prev_hold) chk("hold_data", flit_out_data, prev_data);
    if (since_rst > 0) chk("in_rdy", 64'(flit_in_rdy), 64'(sb.size() < DEPTH));
    chk("err_oversize", 64'(err_oversize), 64'(err_m));
    if (flit_out_val && flit_out_rdy && sb.size() > 0) begin
      last_out_fire = 1;
      d = sb.pop_front();
      chk("out_data", flit_out_data, d);
      if (out_left == 0) begin
        started++;
        out_left = lenf(d);
        if (out_left == 0) out_tot++;
      end else begin
        out_left--;
        if (out_left == 0) out_tot++;
      end
    end
    prev_hold = flit_out_val && !flit_out_rdy;
    prev_data = flit_out_data;
    if (flit_in_val && flit_in_rdy) begin
      last_in_fire = 1;
      sb.push_back(flit_in_data);
      if (in_left == 0) begin
        l = lenf(flit_in_data);
        if (l == 0 || l >= DEPTH) begin released++; rel_tot++; end
        if (l >= DEPTH) begin in_over = 1; err_m = 1; end
        in_left = l;
      end else begin
        in_left--;
        if (in_left == 0) begin
          if (!in_over) begin released++; rel_tot++; end
          in_over = 0;
        end
      end
    end
    since_rst++;
    @(posedge chipset_clk); #1;
  endtask
  task automatic push_flit(input logic [63:0] d);
    int n;
    n = 0;
    flit_in_val = 1'b1;
    flit_in_data = d;
    do begin tick(); n++; end while (!last_in_fire && n < 300);
    chk("push_timeout", 64'(last_in_fire), 64'(1));
    flit_in_val = 1'b0;
  endtask
  task automatic send_pkt(input int len);
    push_flit(mk_hdr(len));
    for (int i = 0; i < len; i++) push_flit({$urandom, $urandom});
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 1000) begin tick(); n++; end
    chk("drain", 64'(sb.size()), 64'(0));
  endtask
  task automatic chk_stats();
`ifdef MEM_PKT_GATE_STATS_EN
    chk("stat_in", 64'(stat_pkts_in), 64'(rel_tot));
    chk("stat_out", 64'(stat_pkts_out), 64'(out_tot));
`else
    chk("stat_zero", {stat_pkts_in, stat_pkts_out}, 64'(0));
`endif
  endtask
  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    logic [63:0] q[$];
    logic [31:0] s_in, s_out;
    int l;
    repeat (3) tick();
    chipset_rst = 1'b0;
    tick();
    chk("rdy_after_rst", 64'(flit_in_rdy), 64'(1));
    // 1: egress gated by init_done, then back-to-back release
    flit_out_rdy = 1'b1;
    send_pkt(2);
    chk("gated0", 64'(flit_out_val), 64'(0));
    repeat (4) begin tick(); chk("gated", 64'(flit_out_val), 64'(0)); end
    init_done = 1'b1;
    repeat (3) begin tick(); chk("b2b", 64'(last_out_fire), 64'(1)); end
    tick();
    chk("t1_empty", 64'(sb.size()), 64'(0));
    // 2: slow producer holds the packet back until its last flit lands
    push_flit(mk_hdr(3));
    push_flit({$urandom, $urandom});
    push_flit({$urandom, $urandom});
    repeat (5) begin tick(); chk("sf_hold", 64'(flit_out_val), 64'(0)); end
    push_flit({$urandom, $urandom});
    chk("sf_release", 64'(flit_out_val), 64'(1));
    drain();
    // 3: fill to DEPTH with egress blocked
    s_in = stat_pkts_in;
    s_out = stat_pkts_out;
    flit_out_rdy = 1'b0;
    repeat (4) send_pkt(3);
    tick();
    chk("full_rdy", 64'(flit_in_rdy), 64'(0));
    flit_out_rdy = 1'b1;
    drain();
    tick();
`ifdef MEM_PKT_GATE_STATS_EN
    chk("t3_stat_in", 64'(stat_pkts_in - s_in), 64'(4));
    chk("t3_stat_out", 64'(stat_pkts_out - s_out), 64'(4));
`endif
    chk_stats();
    // 4: oversize packet cuts through
    push_flit(mk_hdr(20));
    chk("ovs_err", 64'(err_oversize), 64'(1));
    chk("ovs_val", 64'(flit_out_val), 64'(1));
    for (int i = 0; i < 20; i++) push_flit({$urandom, $urandom});
    drain();
    // 5: init_done drop mid-packet only blocks the next packet
    flit_out_rdy = 1'b0;
    send_pkt(4);
    send_pkt(1);
    flit_out_rdy = 1'b1;
    tick();
    chk("t5_hdr", 64'(last_out_fire), 64'(1));
    init_done = 1'b0;
    repeat (4) begin tick(); chk("t5_body", 64'(last_out_fire), 64'(1)); end
    repeat (4) begin tick(); chk("t5_held", 64'(last_out_fire), 64'(0)); end
    chk("t5_left", 64'(sb.size()), 64'(2));
    init_done = 1'b1;
    drain();
    // 6: reset mid-packet
    flit_out_rdy = 1'b0;
    push_flit(mk_hdr(3));
    push_flit({$urandom, $urandom});
    chipset_rst = 1'b1;
    tick();
    chk("rst_val", 64'(flit_out_val), 64'(0));
    chk("rst_rdy", 64'(flit_in_rdy), 64'(0));
    chipset_rst = 1'b0;
    tick();
    tick();
    flit_out_rdy = 1'b1;
    send_pkt(2);
    drain();
    chk_stats();
    // random traffic
    for (int i = 0; i < 1200; i++) begin
      if (q.size() == 0) begin
        l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 20)) : int'($urandom_range(0, 6));
        q.push_back(mk_hdr(l));
        for (int j = 0; j < l; j++) q.push_back({$urandom, $urandom});
      end
      flit_in_val = ($urandom_range(0, 3) != 0);
      flit_in_data = q[0];
      flit_out_rdy = ($urandom_range(0, 2) != 0);
      init_done = ($urandom_range(0, 15) != 0);
      tick();
      if (last_in_fire) void'(q.pop_front());
    end
    flit_in_val = 1'b0;
    init_done = 1'b1;
    flit_out_rdy = 1'b1;
    while (q.size() > 0) push_flit(q.pop_front());
    drain();
    tick();
    chk("pkts_balanced", 64'(started), 64'(released));
    chk("out_idle", 64'(out_left), 64'(0));
    chk_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
